// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: command sequencer for the regfile/operand-mux/ALU datapath.
// Commands are queued in a small FIFO, issued one at a time (IDLE -> EXEC -> RESP),
// and the ALU result/EQ flag is returned on a valid/ready response channel.
// Optional build macro SEQ_STATS_EN adds a 32-bit retired-command counter port.
//
// state | meaning
// IDLE  | nothing in flight, waiting for the FIFO to become non-empty
// EXEC  | single cycle driving the datapath; result captured at its closing edge
// RESP  | response held on rsp_* until the consumer accepts it
module alu_seq_ctrl #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_rd,
    input  logic [ADDR_WIDTH-1:0] cmd_rs1,
    input  logic [ADDR_WIDTH-1:0] cmd_rs2,
    input  logic [DATA_WIDTH-1:0] cmd_imm,
    output logic [ADDR_WIDTH-1:0] AD1,
    output logic [ADDR_WIDTH-1:0] AD2,
    output logic [ADDR_WIDTH-1:0] AD3,
    output logic                  WE3,
    output logic                  ALUsrc,
    output logic                  ALUctrl,
    output logic [DATA_WIDTH-1:0] ImmOp,
    input  logic [DATA_WIDTH-1:0] ALUout,
    input  logic                  EQ,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_eq,
    output logic                  busy
`ifdef SEQ_STATS_EN
    ,
    output logic [31:0]           retired_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [1:0]            op;
        logic [ADDR_WIDTH-1:0] rd;
        logic [ADDR_WIDTH-1:0] rs1;
        logic [ADDR_WIDTH-1:0] rs2;
        logic [DATA_WIDTH-1:0] imm;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    cmd_t                  fifo_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    state_t                state_q, state_d;
    cmd_t                  cur_q, cur_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_eq_q, rsp_eq_d;
    logic                  push, pop, empty, full, exec;
    cmd_t                  cmd_in;

    assign cmd_in = '{op: cmd_op, rd: cmd_rd, rs1: cmd_rs1, rs2: cmd_rs2, imm: cmd_imm};

    // Next-state, FIFO pointer and response-capture logic.
    always_comb begin
        empty      = (count_q == '0);
        full       = (count_q == CNT_W'(DEPTH));
        push       = cmd_valid && !full;
        pop        = 1'b0;
        state_d    = state_q;
        cur_d      = cur_q;
        rsp_data_d = rsp_data_q;
        rsp_eq_d   = rsp_eq_q;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d = ALUout;
                rsp_eq_d   = EQ;
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = EXEC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            cur_d = fifo_q[rd_ptr_q];
        end
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= cmd_in;
        end
    end

    // Control state, pointers and captured response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            cur_q      <= '0;
            rsp_data_q <= '0;
            rsp_eq_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            cur_q      <= cur_d;
            rsp_data_q <= rsp_data_d;
            rsp_eq_q   <= rsp_eq_d;
        end
    end

    // Datapath drive: only active in EXEC; WE3 also blocked by rst so a reset
    // landing in EXEC cannot commit a write.
    always_comb begin
        exec    = (state_q == EXEC);
        AD1     = exec ? cur_q.rs1 : '0;
        AD2     = exec ? cur_q.rs2 : '0;
        AD3     = exec ? cur_q.rd  : '0;
        ImmOp   = exec ? cur_q.imm : '0;
        ALUsrc  = exec && cur_q.op[0];
        ALUctrl = exec && cur_q.op[1];
        WE3     = exec && !cur_q.op[1] && (cur_q.rd != '0) && !rst;
    end

    assign cmd_ready = !full;
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_eq    = rsp_eq_q;
    assign busy      = !empty || (state_q != IDLE);

`ifdef SEQ_STATS_EN
    logic [31:0] retired_cnt_q, retired_cnt_d;

    // Retired-command count, wraps naturally at 2^32.
    always_comb begin
        retired_cnt_d = retired_cnt_q + 32'(rsp_valid && rsp_ready);
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_cnt_q <= '0;
        end else begin
            retired_cnt_q <= retired_cnt_d;
        end
    end

    assign retired_cnt = retired_cnt_q;
`endif

endmodule
